// File: rtl/vending_credit_if.sv
// Coin-acceptor / change-dispenser / display signal bundle for vending_credit.
// slave = vending_credit side, master = surrounding logic (acceptor, dispenser, display).
interface vending_credit_if #(
   parameter int unsigned CREDIT_W = 4
);
   logic                nickel;
   logic                dime;
   logic                quarter;
   logic                cancel;
   logic                change_ready;
   logic                soda;
   logic                change_valid;
   logic                change_dime;
   logic                coin_reject;
   logic [CREDIT_W-1:0] credit;
   logic                busy;

   modport slave (
      input  nickel, dime, quarter, cancel, change_ready,
      output soda, change_valid, change_dime, coin_reject, credit, busy
   );

   modport master (
      output nickel, dime, quarter, cancel, change_ready,
      input  soda, change_valid, change_dime, coin_reject, credit, busy
   );
endinterface

// File: rtl/vending_credit.sv
// Credit-counting vending controller: vend at PRICE, refund/change as a serial coin stream.
// Optional dime change selected by macro VENDING_DIME_CHANGE_EN (default: nickels only).
module vending_credit #(
   parameter int unsigned CREDIT_W = 4,
   parameter int unsigned PRICE    = 4
) (
   input logic            clk,
   input logic            rst,
   vending_credit_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StVend   = 2'b01,
      StChange = 2'b10
   } state_e;

   localparam logic [CREDIT_W:0] PriceW  = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W:0] MaxCred = {1'b0, {CREDIT_W{1'b1}}};

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                coin_reject_q, coin_reject_d;

   logic                coin;
   logic [CREDIT_W:0]   coin_val;
   logic [CREDIT_W:0]   sum;
   logic                offer_dime;
   logic                offer_valid;
   logic [CREDIT_W-1:0] dec;

   // Nickel > dime > quarter when several strobes coincide
   always_comb begin
      coin_val = '0;
      if (bus.nickel) begin
         coin_val = (CREDIT_W+1)'(1);
      end else if (bus.dime) begin
         coin_val = (CREDIT_W+1)'(2);
      end else if (bus.quarter) begin
         coin_val = (CREDIT_W+1)'(5);
      end
   end

   assign coin        = bus.nickel | bus.dime | bus.quarter;
   assign sum         = {1'b0, credit_q} + coin_val;
   assign offer_valid = (state_q == StChange) && (credit_q != '0);

`ifdef VENDING_DIME_CHANGE_EN
   assign offer_dime = offer_valid && (credit_q >= CREDIT_W'(2));
`else
   assign offer_dime = 1'b0;
`endif

   assign dec = offer_dime ? CREDIT_W'(2) : CREDIT_W'(1);

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      coin_reject_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.cancel) begin
               coin_reject_d = coin;
               if (credit_q != '0) begin
                  state_d = StChange;
               end
            end else if (coin) begin
               if (sum > MaxCred) begin
                  coin_reject_d = 1'b1;
               end else if (sum >= PriceW) begin
                  credit_d = CREDIT_W'(sum - PriceW);
                  state_d  = StVend;
               end else begin
                  credit_d = CREDIT_W'(sum);
               end
            end
         end
         StVend: begin
            coin_reject_d = coin;
            state_d       = (credit_q != '0) ? StChange : StIdle;
         end
         StChange: begin
            coin_reject_d = coin;
            if (credit_q == '0) begin
               state_d = StIdle;
            end else if (bus.change_ready) begin
               credit_d = credit_q - dec;
               if (credit_q == dec) begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d  = StIdle;
            credit_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         credit_q      <= '0;
         coin_reject_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         coin_reject_q <= coin_reject_d;
      end
   end

   assign bus.soda         = (state_q == StVend);
   assign bus.busy         = (state_q == StVend) || (state_q == StChange);
   assign bus.change_valid = offer_valid;
   assign bus.change_dime  = offer_dime;
   assign bus.coin_reject  = coin_reject_q;
   assign bus.credit       = credit_q;

endmodule

// File: tb/tb_vending_credit.sv
// Directed self-checking bench for vending_credit: default instance plus PRICE=15 instance.
module tb_vending_credit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

`ifdef VENDING_DIME_CHANGE_EN
   localparam bit DimeEn = 1'b1;
`else
   localparam bit DimeEn = 1'b0;
`endif

   always #5 clk = ~clk;

   vending_credit_if #(.CREDIT_W(4)) bus_a ();
   vending_credit_if #(.CREDIT_W(4)) bus_b ();

   vending_credit #(.CREDIT_W(4), .PRICE(4)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   vending_credit #(.CREDIT_W(4), .PRICE(15)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int soda, input int cv, input int cr,
                        input int credit, input int busy);
      chk({tag, ".soda"}, int'(bus_a.soda), soda);
      chk({tag, ".change_valid"}, int'(bus_a.change_valid), cv);
      chk({tag, ".coin_reject"}, int'(bus_a.coin_reject), cr);
      chk({tag, ".credit"}, int'(bus_a.credit), credit);
      chk({tag, ".busy"}, int'(bus_a.busy), busy);
   endtask

   // Apply one coin strobe (n/d/q) to instance a for one cycle
   task automatic coin_a(input bit n, input bit d, input bit q);
      bus_a.nickel  = n;
      bus_a.dime    = d;
      bus_a.quarter = q;
      tick();
      bus_a.nickel  = 1'b0;
      bus_a.dime    = 1'b0;
      bus_a.quarter = 1'b0;
   endtask

   task automatic coin_b(input bit n, input bit d, input bit q);
      bus_b.nickel  = n;
      bus_b.dime    = d;
      bus_b.quarter = q;
      tick();
      bus_b.nickel  = 1'b0;
      bus_b.dime    = 1'b0;
      bus_b.quarter = 1'b0;
   endtask

   // Drain instance a from CHANGE with ready high; expected coin per step from a small model
   task automatic drain(input string tag, input int c);
      int guard = 0;
      bus_a.change_ready = 1'b1;
      while (c > 0 && guard < 20) begin
         chk({tag, ".cv"}, int'(bus_a.change_valid), 1);
         chk({tag, ".credit"}, int'(bus_a.credit), c);
         chk({tag, ".dime"}, int'(bus_a.change_dime), (DimeEn && c >= 2) ? 1 : 0);
         chk({tag, ".soda"}, int'(bus_a.soda), 0);
         c = c - ((DimeEn && c >= 2) ? 2 : 1);
         tick();
         guard++;
      end
      bus_a.change_ready = 1'b0;
      chk_a({tag, ".done"}, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bus_a.nickel = 0; bus_a.dime = 0; bus_a.quarter = 0;
      bus_a.cancel = 0; bus_a.change_ready = 0;
      bus_b.nickel = 0; bus_b.dime = 0; bus_b.quarter = 0;
      bus_b.cancel = 0; bus_b.change_ready = 1;

      // Reset
      tick();
      tick();
      chk_a("reset", 0, 0, 0, 0, 0);
      chk("reset.dime", int'(bus_a.change_dime), 0);
      chk("reset_b.credit", int'(bus_b.credit), 0);
      rst = 1'b0;

      // Four nickels: vend on the 4th, no change
      coin_a(1, 0, 0); chk_a("n1", 0, 0, 0, 1, 0);
      coin_a(1, 0, 0); chk_a("n2", 0, 0, 0, 2, 0);
      coin_a(1, 0, 0); chk_a("n3", 0, 0, 0, 3, 0);
      coin_a(1, 0, 0); chk_a("n4_vend", 1, 0, 0, 0, 1);
      tick();          chk_a("n4_after", 0, 0, 0, 0, 0);

      // Nickel then quarter: vend with 2 units change
      coin_a(1, 0, 0); chk_a("nq_n", 0, 0, 0, 1, 0);
      coin_a(0, 0, 1); chk_a("nq_vend", 1, 0, 0, 2, 1);
      tick();
      drain("nq_change", 2);

      // Same, but dispenser stalls and a dime arrives during CHANGE
      coin_a(1, 0, 0);
      coin_a(0, 0, 1); chk_a("stall_vend", 1, 0, 0, 2, 1);
      tick();          chk_a("stall_c0", 0, 1, 0, 2, 1);
      tick();          chk_a("stall_c1", 0, 1, 0, 2, 1);
      coin_a(0, 1, 0); chk_a("stall_rej", 0, 1, 1, 2, 1);
      tick();          chk_a("stall_c3", 0, 1, 0, 2, 1);
      tick();          chk_a("stall_c4", 0, 1, 0, 2, 1);
      drain("stall_change", 2);

      // Dime then cancel: refund
      coin_a(0, 1, 0); chk_a("dc_dime", 0, 0, 0, 2, 0);
      bus_a.cancel = 1'b1;
      tick();
      bus_a.cancel = 1'b0;
      drain("dc_refund", 2);

      // Cancel with zero credit is ignored; a coalescing coin is still rejected
      bus_a.cancel = 1'b1;
      tick();          chk_a("cancel0", 0, 0, 0, 0, 0);
      coin_a(1, 0, 0); chk_a("cancel0_coin", 0, 0, 1, 0, 0);
      bus_a.cancel = 1'b0;
      tick();          chk_a("cancel0_after", 0, 0, 0, 0, 0);

      // Simultaneous strobes: nickel wins, no reject
      coin_a(1, 0, 1); chk_a("prio_nq", 0, 0, 0, 1, 0);
      coin_a(0, 1, 1); chk_a("prio_dq", 0, 0, 0, 3, 0);

      // PRICE=15 instance: overflow reject then exact vend
      coin_b(0, 0, 1); chk("b_q1", int'(bus_b.credit), 5);
      coin_b(0, 0, 1); chk("b_q2", int'(bus_b.credit), 10);
      coin_b(0, 1, 0); chk("b_d", int'(bus_b.credit), 12);
      coin_b(0, 0, 1);
      chk("b_ovf.reject", int'(bus_b.coin_reject), 1);
      chk("b_ovf.credit", int'(bus_b.credit), 12);
      coin_b(1, 0, 0); chk("b_n1", int'(bus_b.credit), 13);
      chk("b_n1.reject", int'(bus_b.coin_reject), 0);
      coin_b(1, 0, 0); chk("b_n2", int'(bus_b.credit), 14);
      coin_b(1, 0, 0);
      chk("b_vend.soda", int'(bus_b.soda), 1);
      chk("b_vend.credit", int'(bus_b.credit), 0);
      tick();
      chk("b_after.soda", int'(bus_b.soda), 0);
      chk("b_after.cv", int'(bus_b.change_valid), 0);
      chk("b_after.busy", int'(bus_b.busy), 0);

      // Reset in the middle of CHANGE with 3 units pending (credit 3 from prio test)
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_a("pre_rst_clean", 0, 0, 0, 0, 0);
      coin_a(0, 1, 0);
      coin_a(0, 0, 1); chk_a("rst_vend", 1, 0, 0, 3, 1);
      tick();          chk_a("rst_change", 0, 1, 0, 3, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_a("rst_mid", 0, 0, 0, 0, 0);
      chk("rst_mid.dime", int'(bus_a.change_dime), 0);
      tick();          chk_a("rst_idle", 0, 0, 0, 0, 0);

      // Credit 3 change: dime+nickel with the option, three nickels without
      coin_a(0, 1, 0);
      coin_a(0, 0, 1); chk_a("c3_vend", 1, 0, 0, 3, 1);
      tick();
      drain("c3_change", 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vending_credit.md
Name: vending_credit

Overview:
- Parametrised successor to the fixed-price soda FSM.
- Accumulates nickel/dime/quarter credit in a counter, vends when credit reaches PRICE, then returns the remainder as a serial coin stream over a valid/ready handshake to the coin dispenser.
- Adds cancel/refund, overflow coin rejection and a visible credit value for the display.
- Sits between the coin acceptor front end and the dispenser/display logic.

Parameters:
- CREDIT_W, 4: credit counter width, in nickel units (5 cents); max credit = 2^CREDIT_W-1; legal range >= 3.
- PRICE, 4: product price in nickel units (4 = 20 cents); legal range 1 .. 2^CREDIT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- nickel  in  1  coin strobe, value 1 unit, one cycle per coin.
- dime  in  1  coin strobe, value 2 units.
- quarter  in  1  coin strobe, value 5 units.
- cancel  in  1  refund request, one-cycle strobe.
- change_ready  in  1  dispenser accepts one coin this cycle.
- soda  out  1  one-cycle vend pulse.
- change_valid  out  1  coin offered to dispenser.
- change_dime  out  1  offered coin is a dime (see Optional Feature).
- coin_reject  out  1  one-cycle pulse: inserted coin returned, not credited.
- credit  out  CREDIT_W  current credit in nickel units.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- All outputs are registered or decoded from state/credit registers only. No combinational path from inputs to outputs.
- Reset: state=IDLE; credit=0; soda, change_valid, change_dime, coin_reject and busy all 0. Reset overrides everything, including mid-VEND or mid-CHANGE: the pending change is discarded.
- Coin value v: nickel=1, dime=2, quarter=5. If more than one strobe is high, priority is nickel > dime > quarter. The lower-priority coins are ignored, with no reject.
- IDLE:
  - cancel=1 and credit>0: go to CHANGE. Any coin in the same cycle is rejected.
  - cancel=1 and credit=0: ignored. A coin in the same cycle is still rejected.
  - Coin with credit+v > 2^CREDIT_W-1: coin_reject=1 for the next cycle; credit and state unchanged. Compute the sum at CREDIT_W+1 bits.
  - Coin with credit+v >= PRICE: credit <= credit+v-PRICE; state <= VEND.
  - Otherwise: credit <= credit+v; stay in IDLE.
- VEND:
  - Lasts exactly one cycle; soda=1 and busy=1.
  - Next state is CHANGE if credit>0, else IDLE.
  - Latency: the coin sampled at edge k produces soda high from edge k to edge k+1.
- CHANGE:
  - change_valid=1 and busy=1.
  - On an edge with change_ready=1, credit decrements by the coin value (1, or 2 when change_dime=1).
  - Return to IDLE on the handshake that takes credit to 0.
  - change_ready=0: change_valid holds and credit holds indefinitely.
- Coins during VEND or CHANGE: coin_reject pulses in the next cycle and credit is unaffected. cancel is ignored in those states.
- change_valid is never high when credit=0. soda never coincides with change_valid.
- State encoding: IDLE, VEND, CHANGE. The unused encoding recovers to IDLE with credit cleared.

Optional Feature:
- Macro: VENDING_DIME_CHANGE_EN.
- Defined: in CHANGE, if credit>=2 the offered coin is a dime (change_dime=1, decrement 2); otherwise a nickel.
- Undefined: change is always nickels; change_dime is tied to 0.
- Handshake rules and all other behaviour are identical either way.

Test Plan:
- Four nickels on consecutive cycles (defaults) -> soda=1 for exactly one cycle after the 4th coin; change_valid never asserted; credit=0; back to IDLE.
- Nickel then quarter, change_ready=1 (macro off) -> soda pulse; credit=2; then 2 cycles of change_valid=1; credit 2->1->0; busy falls with the last handshake.
- Same as previous, but change_ready=0 for 5 cycles with a dime inserted meanwhile -> change_valid stays 1; credit stays 2; coin_reject pulses once; after ready rises, 2 handshakes complete.
- Dime then cancel -> no soda; credit=2 drained by 2 nickel handshakes. Cancel with credit=0 -> no state change.
- Instance with PRICE=15, CREDIT_W=4: quarter, quarter, dime (credit=12), then quarter -> coin_reject=1, credit stays 12. Then nickel, nickel, nickel -> vend at credit 15, no change.
- rst asserted mid-CHANGE (credit=3) -> next cycle all outputs 0, credit=0, IDLE. With VENDING_DIME_CHANGE_EN, credit=3 -> dime handshake (change_dime=1) then nickel handshake.
